// File: rtl/ripple_count_monitor_pkg.sv
// Shared types and constants for the ripple counter monitor.
//   CNT_W / UFLOW_W  : widths of the tracked count and the underflow counter
//   CNT_MAX          : value a 4-bit down-counter wraps to after 0
//   UFLOW_MAX        : saturation value of the underflow counter
//   trk_state_t      : tracker FSM (INIT until first accepted value, then TRACK)
//   snap_state_t     : snapshot FSM (IDLE, HOLD while snap_valid is high)
package ripple_count_monitor_pkg;

  localparam int CNT_W   = 4;
  localparam int UFLOW_W = 8;

  localparam logic [CNT_W-1:0]   CNT_MAX   = 4'hF;
  localparam logic [UFLOW_W-1:0] UFLOW_MAX = 8'd255;

  typedef enum logic {
    TRK_INIT  = 1'b0,
    TRK_TRACK = 1'b1
  } trk_state_t;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_t;

endpackage

// File: rtl/ripple_count_monitor_sync_filter.sv
// ripple_sync_filter: brings the asynchronous ripple counter outputs into the
// clk domain and only lets a value through once it has been seen unchanged for
// STABLE_CYCLES consecutive synchronized samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt_in     : raw counter bits, asynchronous to clk
//   value      : synchronized value being accepted (valid with accept)
//   accept     : one-cycle strobe, high on the edge that completes a stable run
module ripple_sync_filter
  import ripple_count_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] value,
  output logic             accept
);

  localparam int          LAST   = SYNC_STAGES - 1;
  localparam logic [2:0]  STABLE = 3'(STABLE_CYCLES);

  logic [CNT_W-1:0]       sync_q [SYNC_STAGES];
  // fill_q marks which synchronizer stages hold a real sample since reset, so
  // the reset contents of the chain are never counted toward a stable run.
  logic [SYNC_STAGES-1:0] fill_q;
  logic [CNT_W-1:0]       cand_q;
  logic [2:0]             run_q;   // 0 = no candidate yet
  logic [2:0]             run_next;
  logic                   same;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
      cand_q <= '0;
      run_q  <= '0;
    end else begin
      sync_q[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[LAST]) begin
        cand_q <= sync_q[LAST];
        run_q  <= run_next;
      end
    end
  end

  always_comb begin
    same     = (run_q != 3'd0) && (sync_q[LAST] == cand_q);
    run_next = 3'd1;
    if (same) run_next = (run_q == STABLE) ? run_q : run_q + 3'd1;
  end

  // Fire once per run: when the count reaches STABLE, but not again while an
  // already-accepted value keeps repeating.
  assign accept = fill_q[LAST] && (run_next == STABLE) && !(same && (run_q == STABLE));
  assign value  = sync_q[LAST];

endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: tracks an asynchronous 4-bit ripple down-counter,
// classifies each accepted change (normal step, underflow 0->15, or skip),
// counts underflows and offers a held snapshot of {uflow_count, cnt_sync}.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cnt_in      : raw counter {q4,q3,q2,q1}
//   snap_req    : capture request (ignored while a snapshot is held)
//   snap_ready  : consumer accepts the held snapshot
//   cnt_sync    : last accepted count;  cnt_valid : a value has been accepted
//   uflow_pulse : one cycle per underflow; uflow_count saturates, uflow_ovf sticky
//   err_skip    : one cycle per change that is not a decrement by one
//   snap_valid / snap_data : held snapshot
// Handshake: snap_data is offered while snap_valid=1 and is consumed on the
// edge where snap_valid && snap_ready; it stays constant until then.
module ripple_count_monitor
  import ripple_count_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         cnt_in,
  input  logic                     snap_req,
  input  logic                     snap_ready,
  output logic [CNT_W-1:0]         cnt_sync,
  output logic                     cnt_valid,
  output logic                     uflow_pulse,
  output logic [UFLOW_W-1:0]       uflow_count,
  output logic                     uflow_ovf,
  output logic                     err_skip,
  output logic                     snap_valid,
  output logic [UFLOW_W+CNT_W-1:0] snap_data
);

  trk_state_t       trk_state;
  snap_state_t      snap_state;
  logic [CNT_W-1:0] acc_value;
  logic             acc;

  ripple_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_in(cnt_in),
    .value (acc_value),
    .accept(acc)
  );

  // Tracker: pulses default low every cycle so they last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_state   <= TRK_INIT;
      cnt_sync    <= '0;
      uflow_pulse <= 1'b0;
      uflow_count <= '0;
      uflow_ovf   <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      uflow_pulse <= 1'b0;
      err_skip    <= 1'b0;
      if (acc) begin
        case (trk_state)
          TRK_INIT: begin
            cnt_sync  <= acc_value;
            trk_state <= TRK_TRACK;
          end
          TRK_TRACK: begin
            if (acc_value != cnt_sync) begin
              cnt_sync <= acc_value;
              // Wrap check first: 0 - 1 mod 16 is 15, which is an underflow,
              // not an ordinary step.
              if (cnt_sync == '0 && acc_value == CNT_MAX) begin
                uflow_pulse <= 1'b1;
                if (uflow_count == UFLOW_MAX) uflow_ovf   <= 1'b1;
                else                          uflow_count <= uflow_count + 8'd1;
              end else if (acc_value != (cnt_sync - 4'd1)) begin
                err_skip <= 1'b1;
              end
            end
          end
          default: trk_state <= TRK_INIT;
        endcase
      end
    end
  end

  // Snapshot: captures the register values as they were before this edge, so
  // a request coinciding with an update sees the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_state <= SNAP_IDLE;
      snap_data  <= '0;
    end else begin
      case (snap_state)
        SNAP_IDLE: if (snap_req) begin
          snap_data  <= {uflow_count, cnt_sync};
          snap_state <= SNAP_HOLD;
        end
        SNAP_HOLD: if (snap_ready) snap_state <= SNAP_IDLE;
        default:   snap_state <= SNAP_IDLE;
      endcase
    end
  end

  assign cnt_valid  = (trk_state == TRK_TRACK);
  assign snap_valid = (snap_state == SNAP_HOLD);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor (default parameters: latency 4).
module tb_ripple_count_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cnt_in;
  logic        snap_req;
  logic        snap_ready;
  logic [3:0]  cnt_sync;
  logic        cnt_valid;
  logic        uflow_pulse;
  logic [7:0]  uflow_count;
  logic        uflow_ovf;
  logic        err_skip;
  logic        snap_valid;
  logic [11:0] snap_data;

  ripple_count_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .cnt_sync   (cnt_sync),
    .cnt_valid  (cnt_valid),
    .uflow_pulse(uflow_pulse),
    .uflow_count(uflow_count),
    .uflow_ovf  (uflow_ovf),
    .err_skip   (err_skip),
    .snap_valid (snap_valid),
    .snap_data  (snap_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // monitor counters, updated once per cycle in tick()
  int   n_uf, n_err, n_chg;
  logic saw_zero;
  logic [3:0] prev_sync;

  typedef struct {
    logic [3:0] cnt;
    int         exp_sync;
    int         exp_ucount;
    int         exp_uf;
    int         exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (uflow_pulse) n_uf++;
    if (err_skip) n_err++;
    if (cnt_sync != prev_sync) n_chg++;
    if (cnt_sync == 4'd0) saw_zero = 1'b1;
    prev_sync = cnt_sync;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_mon();
    n_uf = 0; n_err = 0; n_chg = 0; saw_zero = 1'b0;
    prev_sync = cnt_sync;
  endtask

  initial begin
    vecs[0] = '{4'd1,  1,  0, 0, 1};  // 7 -> 1 skip
    vecs[1] = '{4'd0,  0,  0, 0, 0};
    vecs[2] = '{4'd15, 15, 1, 1, 0};  // underflow
    vecs[3] = '{4'd14, 14, 1, 0, 0};
    vecs[4] = '{4'd5,  5,  1, 0, 1};  // 14 -> 5 skip
    vecs[5] = '{4'd2,  2,  1, 0, 1};  // 5 -> 2 skip
    vecs[6] = '{4'd1,  1,  1, 0, 0};
    vecs[7] = '{4'd0,  0,  1, 0, 0};
    vecs[8] = '{4'd15, 15, 2, 1, 0};  // underflow

    rst_n = 1'b0; cnt_in = 4'd9; snap_req = 1'b0; snap_ready = 1'b0;
    clr_mon();
    ticks(2);
    check("rst_cnt_sync", cnt_sync, 0);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_uflow_count", uflow_count, 0);
    check("rst_uflow_ovf", uflow_ovf, 0);
    check("rst_snap_valid", snap_valid, 0);
    check("rst_snap_data", snap_data, 0);

    // first acceptance: exactly 4 cycles after release
    rst_n = 1'b1;
    clr_mon();
    ticks(3);
    check("lat_valid_early", cnt_valid, 0);
    tick();
    check("lat_valid", cnt_valid, 1);
    check("lat_cnt_sync", cnt_sync, 9);
    ticks(2);
    check("lat_no_pulses", n_uf + n_err, 0);

    // glitch to 0 for one cycle is filtered; only 8 -> 7 seen
    cnt_in = 4'd8; ticks(6);
    check("glitch_pre", cnt_sync, 8);
    clr_mon();
    cnt_in = 4'd0; tick();
    cnt_in = 4'd8; ticks(4);
    cnt_in = 4'd7; ticks(6);
    check("glitch_final", cnt_sync, 7);
    check("glitch_changes", n_chg, 1);
    check("glitch_saw_zero", saw_zero, 0);
    check("glitch_err", n_err, 0);

    // table-driven steps
    for (int v = 0; v < 9; v++) begin
      clr_mon();
      cnt_in = vecs[v].cnt;
      ticks(6);
      check($sformatf("vec%0d_cnt_sync", v), cnt_sync, vecs[v].exp_sync);
      check($sformatf("vec%0d_uflow_count", v), uflow_count, vecs[v].exp_ucount);
      check($sformatf("vec%0d_uflow_pulses", v), n_uf, vecs[v].exp_uf);
      check($sformatf("vec%0d_err_pulses", v), n_err, vecs[v].exp_err);
    end

    // snapshot requested on the same edge as an update captures old values
    cnt_in = 4'd14; ticks(3);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    check("snap_pre_update_data", snap_data, {8'd2, 4'd15});
    check("snap_pre_update_sync", cnt_sync, 14);
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    check("snap_release", snap_valid, 0);

    // hold for several cycles with an update and a second request in between
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    check("hold_valid", snap_valid, 1);
    check("hold_data", snap_data, {8'd2, 4'd14});
    cnt_in = 4'd13; ticks(2);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    ticks(3);
    check("hold_valid_late", snap_valid, 1);
    check("hold_data_late", snap_data, {8'd2, 4'd14});
    check("hold_cnt_sync", cnt_sync, 13);
    snap_ready = 1'b1; snap_req = 1'b1; tick(); snap_ready = 1'b0; snap_req = 1'b0;
    check("hold_cleared", snap_valid, 0);
    tick();
    check("hold_req_ignored", snap_valid, 0);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    check("resnap_data", snap_data, {8'd2, 4'd13});

    // asynchronous reset while holding
    #2 rst_n = 1'b0;
    #1;
    check("arst_snap_valid", snap_valid, 0);
    check("arst_snap_data", snap_data, 0);
    check("arst_cnt_sync", cnt_sync, 0);
    check("arst_uflow_count", uflow_count, 0);
    tick();

    // snapshot before any value has been accepted
    rst_n = 1'b1; cnt_in = 4'd15;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    check("init_snap_valid", snap_valid, 1);
    check("init_snap_data", snap_data, 0);
    check("init_cnt_valid", cnt_valid, 0);
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    ticks(5);
    check("sat_start", cnt_sync, 15);

    // 256 full down cycles: saturation and sticky overflow
    clr_mon();
    for (int u = 1; u <= 256; u++) begin
      for (int v = 14; v >= 0; v--) begin
        cnt_in = 4'(v); ticks(4);
      end
      cnt_in = 4'd15; ticks(4);
      if (u == 255) begin
        check("sat255_count", uflow_count, 255);
        check("sat255_ovf", uflow_ovf, 0);
      end
    end
    check("sat256_count", uflow_count, 255);
    check("sat256_ovf", uflow_ovf, 1);
    check("sat_pulses", n_uf, 256);
    check("sat_err", n_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on cnt_in (legal 2..4).
REQ-002 Parameter STABLE_CYCLES, default 2, consecutive identical synchronized samples required to accept a value (legal 1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cnt_in  input  4  raw ripple down-counter outputs {q4,q3,q2,q1}, q1 = LSB, asynchronous to clk.
REQ-006 snap_req  input  1  one-cycle request to capture a snapshot.
REQ-007 snap_ready  input  1  consumer accepts snapshot when high with snap_valid.
REQ-008 cnt_sync  output  4  last accepted (filtered) count value.
REQ-009 cnt_valid  output  1  high once the first value has been accepted.
REQ-010 uflow_pulse  output  1  one-cycle pulse on an accepted 0 -> 15 transition.
REQ-011 uflow_count  output  8  number of underflows, saturating at 255.
REQ-012 uflow_ovf  output  1  sticky; set when an underflow occurs with uflow_count already 255.
REQ-013 err_skip  output  1  one-cycle pulse on an accepted change that is not a decrement by 1 (mod 16).
REQ-014 snap_valid  output  1  snapshot available.
REQ-015 snap_data  output  12  {uflow_count, cnt_sync} captured at the request.

Function
REQ-016 cnt_in SHALL pass through SYNC_STAGES flops before any other logic uses it.
REQ-017 Filter: a synchronized value SHALL be accepted only after it has been identical for STABLE_CYCLES consecutive edges; any differing sample restarts the run.
REQ-018 Latency from a stable change on cnt_in to the cnt_sync update SHALL be SYNC_STAGES+STABLE_CYCLES cycles (4 with defaults).
REQ-019 Tracker FSM states: INIT (cnt_valid=0) and TRACK (cnt_valid=1); INIT -> TRACK on first acceptance; no other transition except reset.
REQ-020 The first acceptance (INIT -> TRACK) SHALL load cnt_sync and raise no pulse.
REQ-021 In TRACK, acceptance of a value equal to cnt_sync SHALL produce no action.
REQ-022 In TRACK, new = cnt_sync-1 with cnt_sync != 0: normal step, no pulse.
REQ-023 In TRACK, cnt_sync = 0 and new = 15: uflow_pulse for one cycle, uflow_count +1 (saturating), uflow_ovf set if already 255.
REQ-024 In TRACK, any other change: err_skip for one cycle, cnt_sync still updated, uflow_count unchanged.
REQ-025 Snapshot FSM states: IDLE, HOLD; IDLE + snap_req -> HOLD, capturing snap_data; HOLD + snap_ready -> IDLE.
REQ-026 snap_valid SHALL be 1 exactly in HOLD; snap_data SHALL stay constant while in HOLD.
REQ-027 snap_req while in HOLD (including the snap_ready cycle) SHALL be ignored.
REQ-028 snap_req in the same cycle as an underflow/update SHALL capture the pre-update output values.
REQ-029 snap_req while cnt_valid=0 SHALL still capture (cnt_sync=0).

Reset
REQ-030 rst_n low SHALL immediately clear synchronizer flops, filter run, cnt_sync=0, cnt_valid=0, uflow_pulse=0, uflow_count=0, uflow_ovf=0, err_skip=0, snap_valid=0, snap_data=0; FSMs to INIT and IDLE.
REQ-031 Reset mid-filter-run or in HOLD SHALL discard the run/snapshot; no pulse after release.
REQ-032 After rst_n rises, the first acceptance SHALL follow REQ-018/REQ-020.

Structure
REQ-033 Shared package SHALL hold FSM state typedefs (INIT/TRACK, IDLE/HOLD), count width 4, uflow width 8, UFLOW_MAX 255.
REQ-034 One sub-module ripple_sync_filter (synchronizer + stability filter, outputs accepted value + accept strobe); step classification, counter and snapshot stay in the top.

Verification
REQ-035 Reset, cnt_in held at 9 -> cnt_sync=9, cnt_valid=1 exactly 4 cycles after release, no pulses.
REQ-036 Step cnt_in 1 -> 0 -> 15, each held 6 cycles -> exactly one uflow_pulse, uflow_count=1, err_skip never set.
REQ-037 Glitch cnt_in 8 -> 0 for 1 cycle -> 8 then settle at 7 -> cnt_sync goes 8 -> 7 only, no err_skip.
REQ-038 Step cnt_in 5 -> 2 -> err_skip one cycle, cnt_sync=2, uflow_count unchanged.
REQ-039 256 full down cycles -> uflow_count=255, uflow_ovf=1 after 256th underflow.
REQ-040 snap_req with snap_ready low 5 cycles, second snap_req mid-hold -> snap_valid held, snap_data unchanged, cleared on snap_ready; rst_n pulse in HOLD -> snap_valid=0 immediately.
